a2d_spi_resp: RTL
=================

# a2d_spi_resp

Synthesizable SPI responder that models the 8-channel, 12-bit A2D converter on the far end of the A2D SPI link. It supports FPGA bring-up and closed-loop simulation without the physical converter. Each frame runs under one `a2d_SS_n` assertion: the block decodes the 16-bit channel command from `MOSI`, captures that channel's sample from a parallel input bus, and returns it on `MISO` during the second 16-bit frame. All SPI inputs are oversampled in the `clk` domain; no logic is clocked by `SCLK`.

## Interface
- `SYNC_STAGES`, default 2 — synchronizer flops on `SCLK`, `a2d_SS_n`, `MOSI` (min 2).
- `clk` input 1 — system clock.
- `rst_n` input 1 — reset, asynchronous, active-low.
- `SCLK` input 1 — SPI clock from master; idles high.
- `a2d_SS_n` input 1 — slave select, active-low.
- `MOSI` input 1 — command data from master.
- `MISO` output 1 — response data to master.
- `ch_data` input 96 — eight 12-bit samples; channel k at `[12k+11:12k]`.
- `chnnl_out` output 3 — channel decoded from the last command.
- `cmd_vld` output 1 — 1-clk pulse when the command frame completes.
- `cnv_done` output 1 — 1-clk pulse on `a2d_SS_n` rise after a complete 32-bit transaction.
- `frm_err` output 1 — 1-clk pulse on `a2d_SS_n` rise mid-transaction.
- `busy` output 1 — high while not in IDLE.

## Operation
- Synchronize `SCLK`, `a2d_SS_n`, `MOSI` through `SYNC_STAGES` flops. Detect rise and fall from the last two sync stages.
- SPI mode: master changes `MOSI` after `SCLK` falls and samples `MISO` on `SCLK` rise. The responder samples `MOSI` on rise and updates `MISO` on fall.
- `rx_reg[15:0]` shifts in `MOSI` (MSB first) on each detected rise. `bit_cnt` (5 bits) counts rises within a frame, 0..16.
- `tx_reg[15:0]`: on each detected fall, `MISO <= tx_reg[15]` and `tx_reg <= {tx_reg[14:0],1'b1}`.
- States:
  - IDLE: `MISO`=1, `tx_reg`=16'hFFFF, `bit_cnt`=0. Go to CMD on `a2d_SS_n` fall.
  - CMD: shift `rx_reg`. On the 16th rise:
    - `chnnl_out <= rx_reg_next[13:11]`
    - pulse `cmd_vld`
    - load `tx_reg` with the payload for `ch_data` of that channel, sampled at this cycle
    - reset `bit_cnt`
    - go to DATA
  - DATA: shift out `tx_reg`; `rx_reg` keeps shifting (don't-care). On the 16th rise go to DONE.
  - DONE: ignore further edges; `MISO` held 1 after the next fall.
- `a2d_SS_n` rise (synchronized):
  - From DONE: pulse `cnv_done`, go to IDLE.
  - From CMD or DATA: pulse `frm_err`, go to IDLE, leave `chnnl_out` unchanged.
- Payload: `{4'b0000, P}`, where P is the 12-bit sample, inverted or not per Configuration.
- Command bits [15:14] and [10:0] are not checked.

## Timing
- Reset values:
  - `MISO`=1, `chnnl_out`=0, `cmd_vld`=0, `cnv_done`=0, `frm_err`=0, `busy`=0
  - `rx_reg`=0, `tx_reg`=16'hFFFF, state IDLE.
- Edge-detect latency with `SYNC_STAGES`=2: an `SCLK` or `a2d_SS_n` pin transition is acted on at the 3rd `clk` rise after it. `MISO` changes at the 3rd `clk` rise after the `SCLK` pin falls.
- Requirement: `SCLK` high and low phases each ≥ `SYNC_STAGES`+2 `clk`. The A2D master uses 32 `clk` per phase.
- The first `MISO` payload bit (bit 15) is driven on the first fall after the 16th rise of the command frame. It is stable at the next rise.
- `cmd_vld` is asserted in the same cycle `chnnl_out` updates.
- `a2d_SS_n` fall and rise in the same detection cycle as an `SCLK` edge: the `SS_n` event has priority and the `SCLK` edge is ignored.
- `a2d_SS_n` low again while in IDLE immediately after `cnv_done`: starts a new transaction normally.
- Async reset mid-transaction: all state returns to reset values at once. The master's frame in progress is abandoned, with no pulse.

## Configuration
- `A2D_RESP_INV_EN`:
  - Defined: P = `~sample`. This matches the digital core's A2D interface, which inverts `res`.
  - Undefined: P = `sample`, true polarity, for standalone SPI checks.
  - Upper payload nibble is 4'b0000 in both cases.

## Test plan
- Reset: assert `rst_n`=0 mid-frame -> `MISO`=1, `busy`=0, `chnnl_out`=0, no pulses.
- Channel 5, `ch_data` ch5=12'hA5C, INV_EN defined -> `cmd_vld` after 16th rise, `chnnl_out`=5; frame-2 `MISO` bits = 16'h05A3; `cnv_done` on `SS_n` rise.
- Same stimulus, INV_EN undefined -> frame-2 `MISO` = 16'h0A5C.
- Sweep channels 0..7 with distinct samples (12'h100+k), back-to-back transactions with one-clk `SS_n`-high gap -> each returns its own sample; no `frm_err`.
- `SS_n` rises after 10 bits of frame 2 -> `frm_err` one-clk pulse, no `cnv_done`, `chnnl_out` retains decoded value, `MISO`=1.
- Change `ch_data` during frame 2 -> returned value equals the sample present at the 16th rise of frame 1.

Source files
------------

// File: rtl/a2d_spi_resp.sv
// a2d_spi_resp: SPI responder standing in for the 8-channel, 12-bit A2D
// converter. The first 16-bit frame carries the channel command on MOSI. The
// second 16-bit frame returns {4'b0000, sample} on MISO.
// All SPI pins are oversampled in the clk domain. Nothing is clocked by SCLK.
// Build option: define A2D_RESP_INV_EN to return the inverted sample, which
// matches the digital core's A2D interface. Leave it undefined for true
// polarity.
module a2d_spi_resp #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SCLK,
  input  logic        a2d_SS_n,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [95:0] ch_data,
  output logic [2:0]  chnnl_out,
  output logic        cmd_vld,
  output logic        cnv_done,
  output logic        frm_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  state_t state;

  // SCLK and SS_n carry one extra flop so that an edge is detected between
  // the last synchronizer stage and its delayed copy. MOSI is tapped at the
  // stage that lines up with the SCLK rise detection.
  logic [SYNC_STAGES:0]   sclk_sync;
  logic [SYNC_STAGES:0]   ss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;

  logic        sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_bit;
  logic [15:0] rx_reg, rx_next, tx_reg, payload;
  logic [4:0]  bit_cnt;
  logic [2:0]  ch_next;
  logic [11:0] sample;
  logic        unused_rx_msb;

  // Synchronizers. The idle levels are SCLK high and SS_n high, so leaving
  // reset produces no false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '1;
      ss_sync   <= '1;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-1:0], SCLK};
      ss_sync   <= {ss_sync[SYNC_STAGES-1:0], a2d_SS_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
    end
  end

  assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_sync[SYNC_STAGES];
  assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] & sclk_sync[SYNC_STAGES];
  assign ss_rise   = ss_sync[SYNC_STAGES-1] & ~ss_sync[SYNC_STAGES];
  assign ss_fall   = ~ss_sync[SYNC_STAGES-1] & ss_sync[SYNC_STAGES];
  assign mosi_bit  = mosi_sync[SYNC_STAGES-1];

  // Next receive shift value. The channel field is decoded from it, so the
  // 16th command bit is already included when the decode is taken.
  always_comb begin
    rx_next = {rx_reg[14:0], mosi_bit};
    ch_next = rx_next[13:11];
    sample  = ch_data[12*ch_next +: 12];
`ifdef A2D_RESP_INV_EN
    payload = {4'b0000, ~sample};
`else
    payload = {4'b0000, sample};
`endif
  end

  // The oldest command bit shifts out without being examined.
  assign unused_rx_msb = rx_reg[15];

  assign busy = (state != IDLE);

  // Frame sequencer. An SS_n event takes priority over an SCLK edge seen in
  // the same cycle. MOSI is sampled on the SCLK rise and MISO updates on the
  // SCLK fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rx_reg    <= '0;
      tx_reg    <= 16'hFFFF;
      bit_cnt   <= '0;
      MISO      <= 1'b1;
      chnnl_out <= '0;
      cmd_vld   <= 1'b0;
      cnv_done  <= 1'b0;
      frm_err   <= 1'b0;
    end else begin
      cmd_vld  <= 1'b0;
      cnv_done <= 1'b0;
      frm_err  <= 1'b0;
      if (state == IDLE) begin
        MISO    <= 1'b1;
        tx_reg  <= 16'hFFFF;
        bit_cnt <= '0;
        if (ss_fall) state <= CMD;
      end else if (ss_rise) begin
        // A rise before DONE is a truncated transaction. In that case
        // chnnl_out keeps whatever value it last decoded.
        if (state == DONE) cnv_done <= 1'b1;
        else               frm_err  <= 1'b1;
        state   <= IDLE;
        MISO    <= 1'b1;
        tx_reg  <= 16'hFFFF;
        bit_cnt <= '0;
      end else begin
        case (state)
          CMD: begin
            if (sclk_fall) begin
              MISO   <= tx_reg[15];
              tx_reg <= {tx_reg[14:0], 1'b1};
            end
            if (sclk_rise) begin
              rx_reg <= rx_next;
              if (bit_cnt == 5'd15) begin
                chnnl_out <= ch_next;
                cmd_vld   <= 1'b1;
                tx_reg    <= payload;
                bit_cnt   <= '0;
                state     <= DATA;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          DATA: begin
            if (sclk_fall) begin
              MISO   <= tx_reg[15];
              tx_reg <= {tx_reg[14:0], 1'b1};
            end
            if (sclk_rise) begin
              rx_reg  <= rx_next;
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd15) state <= DONE;
            end
          end
          DONE: begin
            if (sclk_fall) MISO <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
